// File: rtl/bcd_clock_alarm.sv
// BCD hh:mm:ss time-of-day counter with 12/24 h mode, alarm (ring timeout + snooze) and hourly chime.
// All digits are read through one combinational mux port; writes are range-checked digit loads.
module bcd_clock_alarm #(
  parameter int HOUR_MODE  = 24,
  parameter int ALARM_SECS = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int CHIME_EN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] wsel_i,
  input  logic [3:0] wdata_i,
  input  logic       alarm_en_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  input  logic [3:0] rsel_i,
  output logic [3:0] rdata_o,
  output logic       pm_o,
  output logic       alarm_on_o,
  output logic       chime_on_o,
  output logic       beep_o,
  output logic       day_pulse_o
);

  localparam bit MODE12       = (HOUR_MODE == 12);
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int RING_W       = $clog2(ALARM_SECS + 1);
  localparam int SNZ_W        = $clog2(SNOOZE_TICKS + 1);
  localparam logic [3:0] RST_H1 = MODE12 ? 4'd1 : 4'd0;
  localparam logic [3:0] RST_H0 = MODE12 ? 4'd2 : 4'd0;

  typedef struct packed {
    logic [3:0] h1, h0, m1, m0, s1, s0;
  } tod_t;

  typedef struct packed {
    logic [3:0] h1, h0, m1, m0;
  } hm_t;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  localparam tod_t TOD_RST = tod_t'({RST_H1, RST_H0, 16'h0000});
  localparam hm_t  ALM_RST = hm_t'({RST_H1, RST_H0, 8'h00});

  tod_t              tod_q, tod_d, tod_inc, tod_wr;
  hm_t               alm_q, alm_d, alm_wr;
  logic              pm_q, pm_d, pm_inc, pm_wr;
  logic              alm_pm_q, alm_pm_d, alm_pm_wr;
  logic              day_inc, day_d, wr_ok;
  state_e            state_q, state_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [SNZ_W-1:0]  snz_q, snz_d;
  logic [3:0]        chime_q, chime_d, chime_n;
  logic [4:0]        hour_bin;
  logic              tick_eff, hour_top, alarm_hit;
  logic              alarm_on_q, chime_on_q, beep_q, day_q;

  function automatic logic min_ok(input logic [3:0] d1, input logic [3:0] d0);
    return (d1 <= 4'd5) && (d0 <= 4'd9);
  endfunction

  function automatic logic hour_ok(input logic [3:0] d1, input logic [3:0] d0);
    if (MODE12) return ((d1 == 4'd0) && (d0 != 4'd0) && (d0 <= 4'd9)) ||
                       ((d1 == 4'd1) && (d0 <= 4'd2));
    else        return ((d1 <= 4'd1) && (d0 <= 4'd9)) ||
                       ((d1 == 4'd2) && (d0 <= 4'd3));
  endfunction

  // clr and load both swallow a coinciding tick, for the time and for every tick-driven counter.
  assign tick_eff = tick_i & ~clr_i & ~load_i;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tod_inc = tod_q;
    pm_inc  = pm_q;
    day_inc = 1'b0;
    if (tod_q.s0 != 4'd9) tod_inc.s0 = tod_q.s0 + 4'd1;
    else begin
      tod_inc.s0 = 4'd0;
      if (tod_q.s1 != 4'd5) tod_inc.s1 = tod_q.s1 + 4'd1;
      else begin
        tod_inc.s1 = 4'd0;
        if (tod_q.m0 != 4'd9) tod_inc.m0 = tod_q.m0 + 4'd1;
        else begin
          tod_inc.m0 = 4'd0;
          if (tod_q.m1 != 4'd5) tod_inc.m1 = tod_q.m1 + 4'd1;
          else begin
            tod_inc.m1 = 4'd0;
            if (MODE12 && tod_q.h1 == 4'd1 && tod_q.h0 == 4'd2) begin
              tod_inc.h1 = 4'd0;
              tod_inc.h0 = 4'd1;
            end else if (MODE12 && tod_q.h1 == 4'd1 && tod_q.h0 == 4'd1) begin
              tod_inc.h0 = 4'd2;
              pm_inc     = ~pm_q;
              day_inc    = pm_q;
            end else if (!MODE12 && tod_q.h1 == 4'd2 && tod_q.h0 == 4'd3) begin
              tod_inc.h1 = 4'd0;
              tod_inc.h0 = 4'd0;
              day_inc    = 1'b1;
            end else if (tod_q.h0 == 4'd9) begin
              tod_inc.h1 = tod_q.h1 + 4'd1;
              tod_inc.h0 = 4'd0;
            end else begin
              tod_inc.h0 = tod_q.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // The candidate state holds the whole clock, so a single range check covers whichever field changed.
  always_comb begin
    tod_wr    = tod_q;
    alm_wr    = alm_q;
    pm_wr     = pm_q;
    alm_pm_wr = alm_pm_q;
    wr_ok     = 1'b0;
    case (wsel_i)
      4'd0:    tod_wr.s0 = wdata_i;
      4'd1:    tod_wr.s1 = wdata_i;
      4'd2:    tod_wr.m0 = wdata_i;
      4'd3:    tod_wr.m1 = wdata_i;
      4'd4:    tod_wr.h0 = wdata_i;
      4'd5:    tod_wr.h1 = wdata_i;
      4'd6:    alm_wr.m0 = wdata_i;
      4'd7:    alm_wr.m1 = wdata_i;
      4'd8:    alm_wr.h0 = wdata_i;
      4'd9:    alm_wr.h1 = wdata_i;
      4'd10:   pm_wr     = wdata_i[0];
      4'd11:   alm_pm_wr = wdata_i[0];
      default: ;
    endcase
    if (wsel_i <= 4'd9)
      wr_ok = (wdata_i <= 4'd9) && min_ok(tod_wr.s1, tod_wr.s0) && min_ok(tod_wr.m1, tod_wr.m0) &&
              hour_ok(tod_wr.h1, tod_wr.h0) && min_ok(alm_wr.m1, alm_wr.m0) &&
              hour_ok(alm_wr.h1, alm_wr.h0);
    else if (wsel_i <= 4'd11)
      wr_ok = MODE12;
  end

  always_comb begin
    tod_d    = tod_q;
    pm_d     = pm_q;
    alm_d    = alm_q;
    alm_pm_d = alm_pm_q;
    day_d    = 1'b0;
    if (clr_i) begin
      tod_d = TOD_RST;
      pm_d  = 1'b0;
    end else if (load_i) begin
      if (wr_ok) begin
        tod_d    = tod_wr;
        pm_d     = pm_wr;
        alm_d    = alm_wr;
        alm_pm_d = alm_pm_wr;
      end
    end else if (tick_i) begin
      tod_d = tod_inc;
      pm_d  = pm_inc;
      day_d = day_inc;
    end
  end

  assign hour_top  = tick_eff && ({tod_inc.m1, tod_inc.m0, tod_inc.s1, tod_inc.s0} == 16'h0000);
  assign alarm_hit = tick_eff && alarm_en_i && ({tod_inc.s1, tod_inc.s0} == 8'h00) &&
                     ({tod_inc.h1, tod_inc.h0, tod_inc.m1, tod_inc.m0} == alm_q) &&
                     (!MODE12 || (pm_inc == alm_pm_q));
  assign hour_bin  = {1'b0, tod_inc.h1} * 5'd10 + {1'b0, tod_inc.h0};

  always_comb begin
    if (MODE12)                chime_n = hour_bin[3:0];
    else if (hour_bin >= 5'd12) chime_n = 4'(hour_bin - 5'd12);
    else                       chime_n = hour_bin[3:0];
    if (chime_n == 4'd0) chime_n = 4'd12;
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    if (!alarm_en_i) begin
      state_d = IDLE;
      ring_d  = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (alarm_hit) begin
          state_d = RING;
          ring_d  = RING_W'(ALARM_SECS);
        end
        RING: begin
          if (stop_i) begin
            state_d = IDLE;
            ring_d  = '0;
          end else if (snooze_i) begin
            state_d = SNOOZE;
            ring_d  = '0;
            snz_d   = SNZ_W'(SNOOZE_TICKS);
          end else if (tick_eff) begin
            if (ring_q <= RING_W'(1)) begin
              state_d = IDLE;
              ring_d  = '0;
            end else begin
              ring_d = ring_q - RING_W'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop_i) begin
            state_d = IDLE;
            snz_d   = '0;
          end else if (tick_eff) begin
            if (snz_q <= SNZ_W'(1)) begin
              state_d = RING;
              ring_d  = RING_W'(ALARM_SECS);
              snz_d   = '0;
            end else begin
              snz_d = snz_q - SNZ_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          ring_d  = '0;
          snz_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    chime_d = chime_q;
    if (CHIME_EN == 0)                             chime_d = 4'd0;
    else if (state_q != RING && state_d == RING)   chime_d = 4'd0;
    else if (hour_top && state_q != RING)          chime_d = chime_n;
    else if (tick_eff && chime_q != 4'd0)          chime_d = chime_q - 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only; rst clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod_q      <= TOD_RST;
      pm_q       <= 1'b0;
      alm_q      <= ALM_RST;
      alm_pm_q   <= 1'b0;
      state_q    <= IDLE;
      ring_q     <= '0;
      snz_q      <= '0;
      chime_q    <= 4'd0;
      alarm_on_q <= 1'b0;
      chime_on_q <= 1'b0;
      beep_q     <= 1'b0;
      day_q      <= 1'b0;
    end else begin
      tod_q      <= tod_d;
      pm_q       <= pm_d;
      alm_q      <= alm_d;
      alm_pm_q   <= alm_pm_d;
      state_q    <= state_d;
      ring_q     <= ring_d;
      snz_q      <= snz_d;
      chime_q    <= chime_d;
      alarm_on_q <= (state_d == RING);
      chime_on_q <= (chime_d != 4'd0);
      beep_q     <= (state_d == RING) || (chime_d != 4'd0);
      day_q      <= day_d;
    end
  end

  always_comb begin
    rdata_o = 4'd0;
    case (rsel_i)
      4'd0:    rdata_o = tod_q.s0;
      4'd1:    rdata_o = tod_q.s1;
      4'd2:    rdata_o = tod_q.m0;
      4'd3:    rdata_o = tod_q.m1;
      4'd4:    rdata_o = tod_q.h0;
      4'd5:    rdata_o = tod_q.h1;
      4'd6:    rdata_o = alm_q.m0;
      4'd7:    rdata_o = alm_q.m1;
      4'd8:    rdata_o = alm_q.h0;
      4'd9:    rdata_o = alm_q.h1;
      4'd10:   rdata_o = {3'b000, pm_q};
      4'd11:   rdata_o = {3'b000, alm_pm_q};
      default: rdata_o = 4'd0;
    endcase
  end

  assign pm_o        = pm_q;
  assign alarm_on_o  = alarm_on_q;
  assign chime_on_o  = chime_on_q;
  assign beep_o      = beep_q;
  assign day_pulse_o = day_q;

endmodule

// File: tb/tb_bcd_clock_alarm.sv
// Scoreboard bench for bcd_clock_alarm: a 24 h instance (index 0) and a 12 h instance (index 1).
// Expectations are queued as stimulus is applied and compared when the outputs are sampled.
module tb_bcd_clock_alarm;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick[2], clr[2], load[2], alarm_en[2], snooze[2], stop[2];
  logic [3:0] wsel[2], wdata[2], rsel[2], rdata[2];
  logic       pm[2], alarm_on[2], chime_on[2], beep[2], day_pulse[2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {K_TIME, K_DIGIT, K_PM, K_ALARM, K_CHIME, K_BEEP, K_DAY} kind_e;
  typedef struct {
    string       tag;
    int          d;
    kind_e       kind;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bcd_clock_alarm #(.HOUR_MODE(24)) dut24 (
    .clk(clk), .rst(rst), .tick_i(tick[0]), .clr_i(clr[0]), .load_i(load[0]),
    .wsel_i(wsel[0]), .wdata_i(wdata[0]), .alarm_en_i(alarm_en[0]), .snooze_i(snooze[0]),
    .stop_i(stop[0]), .rsel_i(rsel[0]), .rdata_o(rdata[0]), .pm_o(pm[0]),
    .alarm_on_o(alarm_on[0]), .chime_on_o(chime_on[0]), .beep_o(beep[0]),
    .day_pulse_o(day_pulse[0])
  );

  bcd_clock_alarm #(.HOUR_MODE(12)) dut12 (
    .clk(clk), .rst(rst), .tick_i(tick[1]), .clr_i(clr[1]), .load_i(load[1]),
    .wsel_i(wsel[1]), .wdata_i(wdata[1]), .alarm_en_i(alarm_en[1]), .snooze_i(snooze[1]),
    .stop_i(stop[1]), .rsel_i(rsel[1]), .rdata_o(rdata[1]), .pm_o(pm[1]),
    .alarm_on_o(alarm_on[1]), .chime_on_o(chime_on[1]), .beep_o(beep[1]),
    .day_pulse_o(day_pulse[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int d, input kind_e k, input int sel,
                      input logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.d    = d;
    x.kind = k;
    x.sel  = sel;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  // Flags are snapshotted first; digit reads step rsel afterwards while no stimulus is active.
  task automatic drain();
    logic snap_pm[2], snap_al[2], snap_ch[2], snap_bp[2], snap_dy[2];
    exp_t        x;
    logic [31:0] got;
    for (int i = 0; i < 2; i++) begin
      snap_pm[i] = pm[i];
      snap_al[i] = alarm_on[i];
      snap_ch[i] = chime_on[i];
      snap_bp[i] = beep[i];
      snap_dy[i] = day_pulse[i];
    end
    while (sb_q.size() > 0) begin
      x   = sb_q.pop_front();
      got = '0;
      case (x.kind)
        K_TIME: for (int i = 5; i >= 0; i--) begin
          rsel[x.d] = 4'(i);
          #1;
          got = {got[27:0], rdata[x.d]};
        end
        K_DIGIT: begin
          rsel[x.d] = 4'(x.sel);
          #1;
          got = {28'd0, rdata[x.d]};
        end
        K_PM:    got = {31'd0, snap_pm[x.d]};
        K_ALARM: got = {31'd0, snap_al[x.d]};
        K_CHIME: got = {31'd0, snap_ch[x.d]};
        K_BEEP:  got = {31'd0, snap_bp[x.d]};
        K_DAY:   got = {31'd0, snap_dy[x.d]};
        default: got = '1;
      endcase
      check(x.tag, got, x.exp);
    end
  endtask

  task automatic strobe(input int d, input logic c, input logic l, input logic t,
                        input int sel, input int val);
    @(negedge clk);
    clr[d]   = c;
    load[d]  = l;
    tick[d]  = t;
    wsel[d]  = 4'(sel);
    wdata[d] = 4'(val);
    @(negedge clk);
    clr[d]  = 1'b0;
    load[d] = 1'b0;
    tick[d] = 1'b0;
  endtask

  task automatic do_tick(input int d);
    strobe(d, 1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic run_ticks(input int d, input int n);
    for (int i = 0; i < n; i++) do_tick(d);
  endtask

  task automatic wr(input int d, input int sel, input int val);
    strobe(d, 1'b0, 1'b1, 1'b0, sel, val);
  endtask

  task automatic ctl(input int d, input logic snz, input logic stp);
    @(negedge clk);
    snooze[d] = snz;
    stop[d]   = stp;
    @(negedge clk);
    snooze[d] = 1'b0;
    stop[d]   = 1'b0;
  endtask

  // The hour units digit is parked on a value legal for any tens digit before the tens digit is written.
  task automatic set_time(input int d, input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    wr(d, 4, (d == 1) ? 1 : 0);
    wr(d, 5, h1);
    wr(d, 4, h0);
    wr(d, 3, m1);
    wr(d, 2, m0);
    wr(d, 1, s1);
    wr(d, 0, s0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick[i] = 0; clr[i] = 0; load[i] = 0; alarm_en[i] = 0; snooze[i] = 0; stop[i] = 0;
      wsel[i] = 0; wdata[i] = 0; rsel[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) push($sformatf("rst24_rd%0d", i), 0, K_DIGIT, i, 0);
    push("rst24_beep", 0, K_BEEP, 0, 0);
    push("rst24_day", 0, K_DAY, 0, 0);
    push("rst24_alarm", 0, K_ALARM, 0, 0);
    push("rst24_chime", 0, K_CHIME, 0, 0);
    push("rst24_pm", 0, K_PM, 0, 0);
    push("rst12_time", 1, K_TIME, 0, 32'h120000);
    push("rst12_alarm_h1", 1, K_DIGIT, 9, 1);
    push("rst12_alarm_h0", 1, K_DIGIT, 8, 2);
    push("rst12_pm", 1, K_PM, 0, 0);
    drain();

    set_time(0, 2, 3, 5, 9, 5, 8);
    push("t2_load", 0, K_TIME, 0, 32'h235958);
    drain();
    do_tick(0);
    push("t2_tick1", 0, K_TIME, 0, 32'h235959);
    push("t2_tick1_day", 0, K_DAY, 0, 0);
    drain();
    do_tick(0);
    push("t2_wrap", 0, K_TIME, 0, 32'h000000);
    push("t2_wrap_day", 0, K_DAY, 0, 1);
    push("t2_wrap_chime", 0, K_CHIME, 0, 1);
    push("t2_wrap_beep", 0, K_BEEP, 0, 1);
    drain();
    @(negedge clk);
    push("t2_day_one_clk", 0, K_DAY, 0, 0);
    drain();
    run_ticks(0, 11);
    push("t2_chime_11", 0, K_CHIME, 0, 1);
    drain();
    do_tick(0);
    push("t2_chime_12", 0, K_CHIME, 0, 0);
    push("t2_beep_12", 0, K_BEEP, 0, 0);
    drain();

    set_time(1, 1, 1, 5, 9, 5, 9);
    push("t3_load", 1, K_TIME, 0, 32'h115959);
    push("t3_load_pm", 1, K_PM, 0, 0);
    drain();
    do_tick(1);
    push("t3_noon", 1, K_TIME, 0, 32'h120000);
    push("t3_noon_pm", 1, K_PM, 0, 1);
    push("t3_noon_day", 1, K_DAY, 0, 0);
    push("t3_noon_chime", 1, K_CHIME, 0, 1);
    drain();
    run_ticks(1, 11);
    push("t3_chime12_11", 1, K_CHIME, 0, 1);
    drain();
    do_tick(1);
    push("t3_chime12_end", 1, K_CHIME, 0, 0);
    drain();
    wr(1, 4, 3);
    push("t3_bad_hour13", 1, K_TIME, 0, 32'h120012);
    drain();
    set_time(1, 1, 2, 5, 9, 5, 9);
    do_tick(1);
    push("t3_one", 1, K_TIME, 0, 32'h010000);
    push("t3_one_pm", 1, K_PM, 0, 1);
    push("t3_one_day", 1, K_DAY, 0, 0);
    push("t3_one_chime", 1, K_CHIME, 0, 1);
    drain();
    do_tick(1);
    push("t3_chime1_end", 1, K_CHIME, 0, 0);
    drain();
    set_time(1, 1, 1, 5, 9, 5, 9);
    do_tick(1);
    push("t3_midnight", 1, K_TIME, 0, 32'h120000);
    push("t3_midnight_pm", 1, K_PM, 0, 0);
    push("t3_midnight_day", 1, K_DAY, 0, 1);
    drain();

    set_time(0, 0, 3, 5, 9, 5, 9);
    do_tick(0);
    push("t5_hour4", 0, K_TIME, 0, 32'h040000);
    push("t5_chime_on", 0, K_CHIME, 0, 1);
    push("t5_beep_on", 0, K_BEEP, 0, 1);
    drain();
    run_ticks(0, 3);
    push("t5_chime_3", 0, K_CHIME, 0, 1);
    push("t5_beep_3", 0, K_BEEP, 0, 1);
    drain();
    do_tick(0);
    push("t5_chime_4", 0, K_CHIME, 0, 0);
    push("t5_beep_4", 0, K_BEEP, 0, 0);
    drain();

    wr(0, 1, 6);
    wr(0, 0, 10);
    push("t6_bad_digits", 0, K_TIME, 0, 32'h040004);
    drain();
    wr(0, 4, 5);
    wr(0, 5, 2);
    push("t6_bad_hour25", 0, K_TIME, 0, 32'h050004);
    drain();
    wr(0, 5, 1);
    push("t6_hour15", 0, K_TIME, 0, 32'h150004);
    drain();
    strobe(0, 1'b1, 1'b0, 1'b1, 0, 0);
    push("t6_clr_over_tick", 0, K_TIME, 0, 32'h000000);
    drain();
    strobe(0, 1'b0, 1'b1, 1'b1, 0, 7);
    push("t6_load_over_tick", 0, K_TIME, 0, 32'h000007);
    drain();

    wr(0, 8, 7);
    wr(0, 7, 3);
    push("t4_alarm_m0", 0, K_DIGIT, 6, 0);
    push("t4_alarm_m1", 0, K_DIGIT, 7, 3);
    push("t4_alarm_h0", 0, K_DIGIT, 8, 7);
    push("t4_alarm_h1", 0, K_DIGIT, 9, 0);
    drain();
    @(negedge clk);
    alarm_en[0] = 1'b1;
    set_time(0, 0, 7, 3, 0, 0, 0);
    push("t4_load_no_trigger", 0, K_ALARM, 0, 0);
    drain();
    set_time(0, 0, 7, 2, 9, 5, 9);
    do_tick(0);
    push("t4_ring", 0, K_ALARM, 0, 1);
    push("t4_ring_beep", 0, K_BEEP, 0, 1);
    push("t4_ring_time", 0, K_TIME, 0, 32'h073000);
    drain();
    ctl(0, 1'b1, 1'b0);
    push("t4_snoozed", 0, K_ALARM, 0, 0);
    push("t4_snoozed_beep", 0, K_BEEP, 0, 0);
    drain();
    run_ticks(0, 299);
    push("t4_snooze_299", 0, K_ALARM, 0, 0);
    drain();
    do_tick(0);
    push("t4_snooze_300", 0, K_ALARM, 0, 1);
    drain();
    run_ticks(0, 59);
    push("t4_ring_59", 0, K_ALARM, 0, 1);
    drain();
    do_tick(0);
    push("t4_ring_60", 0, K_ALARM, 0, 0);
    push("t4_ring_60_time", 0, K_TIME, 0, 32'h073600);
    drain();

    set_time(0, 0, 7, 2, 9, 5, 9);
    do_tick(0);
    ctl(0, 1'b1, 1'b1);
    push("t4_stop_wins", 0, K_ALARM, 0, 0);
    drain();
    run_ticks(0, 300);
    push("t4_stop_no_reture", 0, K_ALARM, 0, 0);
    drain();

    set_time(0, 0, 7, 2, 9, 5, 9);
    do_tick(0);
    push("t4_ring_again", 0, K_ALARM, 0, 1);
    drain();
    @(negedge clk);
    alarm_en[0] = 1'b0;
    @(negedge clk);
    push("t4_en_low_idle", 0, K_ALARM, 0, 0);
    drain();

    alarm_en[0] = 1'b1;
    set_time(0, 0, 7, 2, 9, 5, 9);
    do_tick(0);
    push("t6_ring_pre_rst", 0, K_ALARM, 0, 1);
    drain();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("t6_rst_alarm", 0, K_ALARM, 0, 0);
    push("t6_rst_beep", 0, K_BEEP, 0, 0);
    push("t6_rst_time", 0, K_TIME, 0, 32'h000000);
    push("t6_rst_alarm_h0", 0, K_DIGIT, 8, 0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    alarm_en[0] = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
